dmem_sized_port: RTL and testbench
==================================

// Module: dmem_sized_port
//
// PURPOSE
// Sized, handshaked data memory for the core's load/store path; next generation of the byte-addressable memory.
// Accepts one request at a time on a valid/ready port: byte/half/word loads and stores, little-endian.
// Loads are sign- or zero-extended. Every request gets a response after a fixed, parametrised latency.
// Out-of-range and malformed requests return an error response instead of failing silently.
//
// PARAMETERS
// AWIDTH        32            request address width
// DEPTH_BYTES   1048576       memory size in bytes; must be a multiple of 4
// BASE_ADDR     32'h01000000  byte address mapped to offset 0
// READ_LATENCY  1             accept-to-response cycles, legal range 1..4
// INIT_FILE     ""            $readmemh word file, loaded little-endian; skipped if ""
//
// PORTS
// clk             in   1       clock
// rst             in   1       reset; synchronous, active-high
// req_vld_i       in   1       request valid
// req_rdy_o       out  1       request ready
// req_we_i        in   1       1 = store, 0 = load
// req_addr_i      in   AWIDTH  byte address
// req_size_i      in   2       00 = byte, 01 = half, 10 = word, 11 = reserved
// req_unsigned_i  in   1       load zero-extend (LBU/LHU); ignored for word and for stores
// req_wdata_i     in   32      store data; only the low 1/2/4 bytes are used, per size
// rsp_vld_o       out  1       response valid, one-cycle pulse
// rsp_rdata_o     out  32      load data, extended; 0 for stores and errors
// rsp_err_o       out  1       request faulted; qualified by rsp_vld_o
//
// BEHAVIOUR
// - Reset values:
//   - FSM state IDLE, latency counter 0.
//   - rsp_vld_o = 0, rsp_rdata_o = 0, rsp_err_o = 0.
//   - req_rdy_o = 0 while rst is high.
//   - Memory contents are not cleared by reset.
// - FSM states:
//   - IDLE: req_rdy_o = 1. When req_vld_i is high, the request is accepted on the clock edge and the FSM moves to BUSY.
//   - BUSY: req_rdy_o = 0. The counter counts READ_LATENCY-1 cycles.
//   - In BUSY's final cycle, rsp_vld_o = 1 and req_rdy_o = 1, so back-to-back requests complete once every READ_LATENCY cycles.
//   - If no new request is accepted in that final cycle, the FSM returns to IDLE.
// - Latency: a request accepted at edge N drives rsp_vld_o high during the cycle after edge N+READ_LATENCY-1.
//   With READ_LATENCY=1 this is the cycle immediately after acceptance.
// - Timing of data:
//   - Stores commit at the acceptance edge.
//   - Load data is sampled at the acceptance edge and held until the response.
// - Address decode:
//   - off = req_addr_i - BASE_ADDR.
//   - Error if req_addr_i < BASE_ADDR.
//   - Error if off + nbytes > DEPTH_BYTES, where nbytes = 1/2/4.
//   - Error if req_size_i = 11.
// - Faulted request: no memory write, rsp_rdata_o = 0, rsp_err_o = 1. Latency is the same as a good request.
// - Data layout:
//   - Little-endian: byte k of the data lives at off+k.
//   - Loads sign-extend from bit 7 (byte) or bit 15 (half) unless req_unsigned_i = 1.
// - No partial accesses: a request that straddles the memory end errors. It is never zero-padded.
// - Reset mid-operation: the pending response is dropped, with no rsp_vld_o pulse. A store that was already accepted stays committed.
// - Inputs are don't-care while req_vld_i = 0 or req_rdy_o = 0.
//
// CONFIGURATION
// - Macro DMEM_MISALIGN_TRAP_EN defined:
//   - A half access with off[0] != 0 is an error.
//   - A word access with off[1:0] != 0 is an error.
//   - Erroring accesses write nothing, return rdata 0 and assert rsp_err_o.
// - Macro not defined: misaligned accesses are performed byte-wise little-endian. Only the range rules above apply.
//
// TESTING
// - Reset, then word store 0xDEADBEEF @BASE+0x10, then word load @BASE+0x10 -> rdata 0xDEADBEEF, err 0, rsp_vld one cycle after accept (LAT=1).
// - Byte loads @BASE+0x13: signed -> 0xFFFFFFDE, unsigned -> 0x000000DE. Half load @BASE+0x10: signed -> 0xFFFFBEEF, unsigned -> 0x0000BEEF.
// - Half store 0x1234_ABCD @BASE+0x20 over 0xFFFFFFFF -> word load reads 0xFFFFABCD. Byte store 0x55 @BASE+0x22 -> word reads 0xFF55ABCD.
// - Word load @BASE+DEPTH_BYTES-2, or at addr BASE-4 -> err 1, rdata 0. Reserved size 11 -> err 1. Memory unchanged on a following readback.
// - Word load @BASE+0x11: with DMEM_MISALIGN_TRAP_EN -> err 1; without -> err 0, rdata = bytes 0x14..0x11.
// - LAT=3, req_vld_i held high -> rsp_vld every 3 cycles. Assert rst during BUSY -> no rsp_vld_o; req_rdy_o = 1 in the first cycle after rst drops.

Source files
------------

// File: rtl/dmem_sized_port_if.sv
// ---------------------------------------------------------------------------
// dmem_sized_port_if
// Request/response bundle for the sized data memory port.
//
// Handshake: a request transfers on a rising clk edge where req_vld_i and
// req_rdy_o are both high. The request fields are only meaningful while
// req_vld_i is high. The memory side never stalls a response: rsp_vld_o is a
// single-cycle pulse, and rsp_rdata_o / rsp_err_o are qualified by it.
//
// Signals (directions as seen by the memory, i.e. the slave modport):
//   req_vld_i       in   request valid
//   req_rdy_o       out  request ready
//   req_we_i        in   1 = store, 0 = load
//   req_addr_i      in   byte address (AWIDTH bits)
//   req_size_i      in   00 byte, 01 half, 10 word, 11 reserved
//   req_unsigned_i  in   zero-extend byte/half loads
//   req_wdata_i     in   store data, low 1/2/4 bytes used
//   rsp_vld_o       out  response valid pulse
//   rsp_rdata_o     out  extended load data, 0 for stores and errors
//   rsp_err_o       out  request faulted
// ---------------------------------------------------------------------------
interface dmem_sized_port_if #(
    parameter int AWIDTH = 32
);
    logic              req_vld_i;
    logic              req_rdy_o;
    logic              req_we_i;
    logic [AWIDTH-1:0] req_addr_i;
    logic [1:0]        req_size_i;
    logic              req_unsigned_i;
    logic [31:0]       req_wdata_i;
    logic              rsp_vld_o;
    logic [31:0]       rsp_rdata_o;
    logic              rsp_err_o;

    modport slave (
        input  req_vld_i, req_we_i, req_addr_i, req_size_i, req_unsigned_i, req_wdata_i,
        output req_rdy_o, rsp_vld_o, rsp_rdata_o, rsp_err_o
    );

    modport master (
        output req_vld_i, req_we_i, req_addr_i, req_size_i, req_unsigned_i, req_wdata_i,
        input  req_rdy_o, rsp_vld_o, rsp_rdata_o, rsp_err_o
    );
endinterface

// File: rtl/dmem_sized_port.sv
// ---------------------------------------------------------------------------
// dmem_sized_port
// Byte-addressable, little-endian data memory with byte/half/word loads and
// stores on a valid/ready request port. Every accepted request produces one
// response pulse READ_LATENCY cycles later; out-of-range, reserved-size (and,
// optionally, misaligned) requests return rsp_err_o = 1 with no side effect.
//
// Ports:
//   clk        clock
//   rst        synchronous, active-high reset (memory contents are kept)
//   bus        dmem_sized_port_if.slave request/response bundle
//   dbg_state  current FSM state (0 = IDLE, 1 = BUSY) for observation
//
// Parameters:
//   AWIDTH, DEPTH_BYTES (multiple of 4), BASE_ADDR,
//   READ_LATENCY (1..4), INIT_FILE (initial image name, unused here)
//
// Build option:
//   DMEM_MISALIGN_TRAP_EN  when defined, halves not on a 2-byte boundary and
//                          words not on a 4-byte boundary fault; otherwise
//                          they are performed byte-wise.
// ---------------------------------------------------------------------------
module dmem_sized_port #(
  parameter int                AWIDTH       = 32,
  parameter int                DEPTH_BYTES  = 1048576,
  parameter logic [AWIDTH-1:0] BASE_ADDR    = 32'h0100_0000,
  parameter int                READ_LATENCY = 1,
  parameter                    INIT_FILE    = ""
) (
  input  logic              clk,
  input  logic              rst,
  dmem_sized_port_if.slave  bus,
  output logic              dbg_state
);
  localparam int WORDS = DEPTH_BYTES / 4;
  localparam int WAW   = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [AWIDTH:0] DEPTH_L  = (AWIDTH+1)'(DEPTH_BYTES);
  localparam logic [1:0]      LAST_CNT = 2'(READ_LATENCY - 1);

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  // Word-organised storage; byte k of a word is bits [8k+7:8k] (little-endian).
  logic [31:0] mem [WORDS];

  // ---------------- address decode ----------------
  logic [AWIDTH-1:0] off;
  logic [AWIDTH:0]   end_off;
  logic [2:0]        nbytes;
  logic              below_base;
  logic              range_err;
  logic              size_err;
  logic              mis_err;
  logic              req_err;

  assign off        = bus.req_addr_i - BASE_ADDR;
  assign below_base = bus.req_addr_i < BASE_ADDR;

  always_comb begin
    case (bus.req_size_i)
      2'b00:   nbytes = 3'd1;
      2'b01:   nbytes = 3'd2;
      default: nbytes = 3'd4;
    endcase
  end

  // One extra bit so an access ending exactly at DEPTH_BYTES is still legal
  // and one running past it cannot wrap back into range.
  assign end_off   = {1'b0, off} + (AWIDTH+1)'(nbytes);
  assign range_err = below_base || (end_off > DEPTH_L);
  assign size_err  = (bus.req_size_i == 2'b11);

`ifdef DMEM_MISALIGN_TRAP_EN
  assign mis_err = ((bus.req_size_i == 2'b01) && off[0]) ||
                   ((bus.req_size_i == 2'b10) && (off[1:0] != 2'b00));
`else
  assign mis_err = 1'b0;
`endif

  assign req_err = range_err || size_err || mis_err;

  // ---------------- byte lanes ----------------
  // Each of the four data bytes maps independently to (word, lane), which
  // lets misaligned accesses span two words.
  logic [WAW-1:0] widx  [4];
  logic [1:0]     lane  [4];
  logic [7:0]     rbyte [4];

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      widx[k]  = WAW'((off + AWIDTH'(k)) >> 2);
      lane[k]  = 2'(off + AWIDTH'(k));
      rbyte[k] = mem[widx[k]][{lane[k], 3'b000} +: 8];
    end
  end

  logic [31:0] ld_ext;

  always_comb begin
    case (bus.req_size_i)
      2'b00:   ld_ext = bus.req_unsigned_i ? {24'h0, rbyte[0]}
                                           : {{24{rbyte[0][7]}}, rbyte[0]};
      2'b01:   ld_ext = bus.req_unsigned_i ? {16'h0, rbyte[1], rbyte[0]}
                                           : {{16{rbyte[1][7]}}, rbyte[1], rbyte[0]};
      default: ld_ext = {rbyte[3], rbyte[2], rbyte[1], rbyte[0]};
    endcase
  end

  // ---------------- FSM ----------------
  state_t     state, state_n;
  logic [1:0] cnt, cnt_n;
  logic       rdy;
  logic       rsp_vld;
  logic       last;
  logic       accept;

  assign last   = (state == S_BUSY) && (cnt == LAST_CNT);
  assign accept = bus.req_vld_i && rdy;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    rdy     = 1'b0;
    rsp_vld = 1'b0;
    case (state)
      S_IDLE: rdy = 1'b1;
      S_BUSY: begin
        if (last) begin
          rsp_vld = 1'b1;
          rdy     = 1'b1;
        end else begin
          cnt_n = cnt + 2'd1;
        end
      end
      default: ;
    endcase
    if (rst) begin
      rdy = 1'b0;
    end
    // Accepting in BUSY's final cycle restarts the count, giving one
    // response every READ_LATENCY cycles under back-to-back traffic.
    if (bus.req_vld_i && rdy) begin
      state_n = S_BUSY;
      cnt_n   = 2'd0;
    end else if (last) begin
      state_n = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= 2'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Load data and error are captured at acceptance and held to the response.
  logic [31:0] rdata_q;
  logic        err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else if (accept) begin
      err_q   <= req_err;
      rdata_q <= (req_err || bus.req_we_i) ? 32'h0 : ld_ext;
    end
  end

  // Stores commit at the acceptance edge; faulted stores write nothing.
  always_ff @(posedge clk) begin
    if (accept && bus.req_we_i && !req_err) begin
      for (int k = 0; k < 4; k++) begin
        if (3'(k) < nbytes) begin
          mem[widx[k]][{lane[k], 3'b000} +: 8] <= bus.req_wdata_i[8*k +: 8];
        end
      end
    end
  end

  assign bus.req_rdy_o   = rdy;
  assign bus.rsp_vld_o   = rsp_vld;
  assign bus.rsp_rdata_o = rsp_vld ? rdata_q : 32'h0;
  assign bus.rsp_err_o   = rsp_vld ? err_q : 1'b0;
  assign dbg_state       = state;

endmodule

// File: tb/tb_dmem_sized_port.sv
// ---------------------------------------------------------------------------
// tb_dmem_sized_port
// Two instances: dut1 (READ_LATENCY=1) for data behaviour, decode and random
// traffic; dut3 (READ_LATENCY=3) for back-to-back timing and reset-in-BUSY.
// Reference model: sparse byte memory with plain arithmetic decode.
// ---------------------------------------------------------------------------
module tb_dmem_sized_port;
  localparam logic [31:0] B = 32'h0100_0000;
  localparam int          D = 1048576;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst3 = 1'b1;
  logic dbg1, dbg3;

  always #5 clk = ~clk;

  dmem_sized_port_if #(.AWIDTH(32)) bus1 ();
  dmem_sized_port_if #(.AWIDTH(32)) bus3 ();

  dmem_sized_port #(.AWIDTH(32), .DEPTH_BYTES(D), .BASE_ADDR(B), .READ_LATENCY(1), .INIT_FILE(""))
    dut1 (.clk(clk), .rst(rst), .bus(bus1.slave), .dbg_state(dbg1));

  dmem_sized_port #(.AWIDTH(32), .DEPTH_BYTES(D), .BASE_ADDR(B), .READ_LATENCY(3), .INIT_FILE(""))
    dut3 (.clk(clk), .rst(rst3), .bus(bus3.slave), .dbg_state(dbg3));

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  mref [longint];
  logic [32:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Reference behaviour: decode and data rules computed directly on bytes.
  task automatic model_op(input bit we, input logic [31:0] addr, input logic [1:0] size,
                          input bit uns, input logic [31:0] wdata,
                          output logic [31:0] rd, output logic err);
    longint off;
    int     n;
    logic [31:0] raw;
    off = longint'(addr) - longint'(B);
    n   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    err = (addr < B) || (off + n > D) || (size == 2'd3);
`ifdef DMEM_MISALIGN_TRAP_EN
    if ((size == 2'd1 && (off % 2) != 0) || (size == 2'd2 && (off % 4) != 0)) err = 1'b1;
`endif
    rd = 32'h0;
    if (!err) begin
      if (we) begin
        for (int k = 0; k < n; k++) mref[off + k] = wdata[8*k +: 8];
      end else begin
        raw = 32'h0;
        for (int k = 0; k < n; k++) raw = raw | (32'(mref[off + k]) << (8*k));
        if (!uns && n < 4 && raw[8*n-1]) raw = raw | (32'hFFFF_FFFF << (8*n));
        rd = raw;
      end
    end
  endtask

  task automatic do_req(input int sel, input bit we, input logic [31:0] addr, input logic [1:0] size,
                        input bit uns, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int lat);
    int   n;
    logic rdy, vld;
    rdata = 32'h0;
    err   = 1'b0;
    @(negedge clk);
    n = 0;
    rdy = (sel != 0) ? bus3.req_rdy_o : bus1.req_rdy_o;
    while (!rdy && n < 20) begin
      @(negedge clk);
      n++;
      rdy = (sel != 0) ? bus3.req_rdy_o : bus1.req_rdy_o;
    end
    if (!rdy) check("rdy_timeout", 32'(rdy), 32'd1);
    if (sel != 0) begin
      bus3.req_we_i = we; bus3.req_addr_i = addr; bus3.req_size_i = size;
      bus3.req_unsigned_i = uns; bus3.req_wdata_i = wdata; bus3.req_vld_i = 1'b1;
    end else begin
      bus1.req_we_i = we; bus1.req_addr_i = addr; bus1.req_size_i = size;
      bus1.req_unsigned_i = uns; bus1.req_wdata_i = wdata; bus1.req_vld_i = 1'b1;
    end
    @(posedge clk);
    #1;
    bus1.req_vld_i = 1'b0;
    bus3.req_vld_i = 1'b0;
    lat = 0;
    vld = 1'b0;
    while (!vld && lat < 20) begin
      @(negedge clk);
      lat++;
      vld = (sel != 0) ? bus3.rsp_vld_o : bus1.rsp_vld_o;
      if (vld) begin
        rdata = (sel != 0) ? bus3.rsp_rdata_o : bus1.rsp_rdata_o;
        err   = (sel != 0) ? bus3.rsp_err_o : bus1.rsp_err_o;
      end
    end
    if (!vld) check("rsp_timeout", 32'(vld), 32'd1);
  endtask

  // Directed access on dut1: checks against spec constants and keeps the model in step.
  task automatic op1(input string tag, input bit we, input logic [31:0] addr, input logic [1:0] size,
                     input bit uns, input logic [31:0] wdata,
                     input logic [31:0] exp_rd, input logic exp_err);
    logic [31:0] rd, mrd;
    logic        er, merr;
    int          lat;
    model_op(we, addr, size, uns, wdata, mrd, merr);
    do_req(0, we, addr, size, uns, wdata, rd, er, lat);
    check({tag, "_rd"}, rd, exp_rd);
    check({tag, "_err"}, 32'(er), 32'(exp_err));
    check({tag, "_lat"}, 32'(lat), 32'd1);
    check({tag, "_mdl"}, {er, rd[30:0]} ^ {1'b0, rd[31], 30'h0}, {merr, mrd[30:0]} ^ {1'b0, mrd[31], 30'h0});
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    logic [31:0] err_addrs [5];
    logic [12:0] mask, exp_mask;
    logic        seen;

    bus1.req_vld_i = 1'b0; bus1.req_we_i = 1'b0; bus1.req_addr_i = '0;
    bus1.req_size_i = 2'd0; bus1.req_unsigned_i = 1'b0; bus1.req_wdata_i = '0;
    bus3.req_vld_i = 1'b0; bus3.req_we_i = 1'b0; bus3.req_addr_i = '0;
    bus3.req_size_i = 2'd0; bus3.req_unsigned_i = 1'b0; bus3.req_wdata_i = '0;

    // ---- reset ----
    repeat (3) @(negedge clk);
    check("rst_rdy_low", 32'(bus1.req_rdy_o), 32'd0);
    rst = 1'b0;
    rst3 = 1'b0;
    #1;
    check("rst_rsp_vld", 32'(bus1.rsp_vld_o), 32'd0);
    check("rst_rsp_rdata", bus1.rsp_rdata_o, 32'h0);
    check("rst_rsp_err", 32'(bus1.rsp_err_o), 32'd0);
    check("rst_rdy_high", 32'(bus1.req_rdy_o), 32'd1);

    // ---- directed data behaviour (LAT=1) ----
    op1("sw_10",  1, B + 32'h10, 2'd2, 0, 32'hDEAD_BEEF, 32'h0, 0);
    op1("lw_10",  0, B + 32'h10, 2'd2, 0, 32'h0, 32'hDEAD_BEEF, 0);
    op1("lb_13s", 0, B + 32'h13, 2'd0, 0, 32'h0, 32'hFFFF_FFDE, 0);
    op1("lb_13u", 0, B + 32'h13, 2'd0, 1, 32'h0, 32'h0000_00DE, 0);
    op1("lh_10s", 0, B + 32'h10, 2'd1, 0, 32'h0, 32'hFFFF_BEEF, 0);
    op1("lh_10u", 0, B + 32'h10, 2'd1, 1, 32'h0, 32'h0000_BEEF, 0);
    op1("sw_20",  1, B + 32'h20, 2'd2, 0, 32'hFFFF_FFFF, 32'h0, 0);
    op1("sh_20",  1, B + 32'h20, 2'd1, 0, 32'h1234_ABCD, 32'h0, 0);
    op1("lw_20a", 0, B + 32'h20, 2'd2, 0, 32'h0, 32'hFFFF_ABCD, 0);
    op1("sb_22",  1, B + 32'h22, 2'd0, 0, 32'h0000_0055, 32'h0, 0);
    op1("lw_20b", 0, B + 32'h20, 2'd2, 0, 32'h0, 32'hFF55_ABCD, 0);

    // ---- decode / fault ----
    op1("lw_end_m2", 0, B + D - 2, 2'd2, 0, 32'h0, 32'h0, 1);
    op1("lw_base_m4", 0, B - 4, 2'd2, 0, 32'h0, 32'h0, 1);
    op1("rsv_load", 0, B + 32'h10, 2'd3, 0, 32'h0, 32'h0, 1);
    op1("rsv_store", 1, B + 32'h10, 2'd3, 0, 32'h0, 32'h0, 1);
    op1("lw_10_keep", 0, B + 32'h10, 2'd2, 0, 32'h0, 32'hDEAD_BEEF, 0);
    op1("sw_end_m4", 1, B + D - 4, 2'd2, 0, 32'h0BAD_F00D, 32'h0, 0);
    op1("sw_end_m2", 1, B + D - 2, 2'd2, 0, 32'hA5A5_A5A5, 32'h0, 1);
    op1("lw_end_m4", 0, B + D - 4, 2'd2, 0, 32'h0, 32'h0BAD_F00D, 0);
    op1("lb_end_m1", 0, B + D - 1, 2'd0, 1, 32'h0, 32'h0000_000B, 0);
    op1("lb_end",    0, B + D,     2'd0, 1, 32'h0, 32'h0, 1);

    // ---- misaligned word ----
    op1("sw_14", 1, B + 32'h14, 2'd2, 0, 32'h1122_3377, 32'h0, 0);
`ifdef DMEM_MISALIGN_TRAP_EN
    op1("lw_11", 0, B + 32'h11, 2'd2, 0, 32'h0, 32'h0, 1);
`else
    op1("lw_11", 0, B + 32'h11, 2'd2, 0, 32'h0, 32'h77DE_ADBE, 0);
`endif

    // ---- randomized traffic against the model (LAT=1) ----
    for (int w = 0; w < 32; w++) op1("fill", 1, B + 32'(4*w), 2'd2, 0, $urandom, 32'h0, 0);
    err_addrs[0] = B - 1;
    err_addrs[1] = B - 4;
    err_addrs[2] = B + D - 1;
    err_addrs[3] = B + D + 8;
    err_addrs[4] = 32'h0;
    for (int i = 0; i < 250; i++) begin
      logic [31:0] a, wd, mrd;
      logic [1:0]  sz;
      logic [32:0] e;
      logic        merr;
      bit          we, uns;
      int          s;
      a   = ($urandom_range(0, 9) < 8) ? B + 32'($urandom_range(0, 124)) : err_addrs[$urandom_range(0, 4)];
      s   = $urandom_range(0, 7);
      sz  = (s == 7) ? 2'd3 : 2'(s % 3);
      we  = 1'($urandom_range(0, 1));
      uns = 1'($urandom_range(0, 1));
      wd  = $urandom;
      model_op(we, a, sz, uns, wd, mrd, merr);
      exp_q.push_back({merr, mrd});
      do_req(0, we, a, sz, uns, wd, rd, er, lat);
      e = exp_q.pop_front();
      check("rnd_rd", rd, e[31:0]);
      check("rnd_err", 32'(er), 32'(e[32]));
      check("rnd_lat", 32'(lat), 32'd1);
    end

    // ---- LAT=3: back-to-back with valid held high ----
    @(negedge clk);
    bus3.req_we_i = 1'b0; bus3.req_addr_i = B; bus3.req_size_i = 2'd2;
    bus3.req_unsigned_i = 1'b0; bus3.req_vld_i = 1'b1;
    mask = '0;
    exp_mask = '0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      mask[i] = bus3.rsp_vld_o;
      exp_mask[i] = ((i % 3) == 0);
      if (i == 12) bus3.req_vld_i = 1'b0;
    end
    check("b2b_pulses", 32'(mask), 32'(exp_mask));

    // ---- LAT=3: reset while BUSY ----
    @(negedge clk);
    bus3.req_we_i = 1'b1; bus3.req_addr_i = B + 32'h40; bus3.req_size_i = 2'd2;
    bus3.req_wdata_i = 32'hCAFE_F00D; bus3.req_vld_i = 1'b1;
    @(posedge clk);
    #1;
    bus3.req_vld_i = 1'b0;
    @(negedge clk);
    rst3 = 1'b1;
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      seen = seen | bus3.rsp_vld_o;
    end
    check("rst_busy_rdy", 32'(bus3.req_rdy_o), 32'd0);
    rst3 = 1'b0;
    @(posedge clk);
    #1;
    seen = seen | bus3.rsp_vld_o;
    check("rst_busy_no_rsp", 32'(seen), 32'd0);
    check("rst_after_rdy", 32'(bus3.req_rdy_o), 32'd1);
    do_req(1, 0, B + 32'h40, 2'd2, 0, 32'h0, rd, er, lat);
    check("lat3_rd", rd, 32'hCAFE_F00D);
    check("lat3_err", 32'(er), 32'd0);
    check("lat3_lat", 32'(lat), 32'd3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
